hazard_forward_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage pipeline.

---
 rtl/hazard_forward_unit_if.sv | 25 ++
 rtl/hazard_forward_unit.sv | 74 +++++++
 tb/tb_hazard_forward_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: pipeline-side signals of the forwarding/hazard unit.
// master = pipeline registers driving hazard inputs, slave = the hazard unit.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rw, exmem_rw, memwb_rw;
    logic id_hilo, ex_memrd, ex_mfhi, ex_mflo, md_start;
    logic exmem_regwr, memwb_regwr, exmem_mthi, exmem_mtlo, memwb_mthi, memwb_mtlo;
    logic [1:0] fwd_a, fwd_b, fwd_h, fwd_l;
    logic stall, bubble, md_busy;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_rw, exmem_rw, memwb_rw,
        output id_hilo, ex_memrd, ex_mfhi, ex_mflo, md_start,
        output exmem_regwr, memwb_regwr, exmem_mthi, exmem_mtlo, memwb_mthi, memwb_mtlo,
        input  fwd_a, fwd_b, fwd_h, fwd_l, stall, bubble, md_busy, stall_cnt
    );
    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rw, exmem_rw, memwb_rw,
        input  id_hilo, ex_memrd, ex_mfhi, ex_mflo, md_start,
        input  exmem_regwr, memwb_regwr, exmem_mthi, exmem_mtlo, memwb_mthi, memwb_mtlo,
        output fwd_a, fwd_b, fwd_h, fwd_l, stall, bubble, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX-stage bypass selects, load-use and mult/div HI/LO stalls.
// Optional saturating stall counter enabled by HAZARD_PERF_CNT_EN.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_forward_unit_if.slave bus
);
    typedef enum logic {IDLE, LDSTALL} state_t;
    state_t     state_q;
    logic [2:0] ld_cnt_q;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       ld_hit, stall;

    function automatic logic [1:0] gpr_sel(input logic [REG_ADDR_W-1:0] src, em_rw, mw_rw,
                                           input logic em_we, mw_we);
        return (src == '0) ? 2'b00 : (em_we && em_rw == src) ? 2'b01 :
               (mw_we && mw_rw == src) ? 2'b10 : 2'b00;
    endfunction

    assign ld_hit = bus.ex_memrd && bus.ex_rw != '0 &&
                    (bus.ex_rw == bus.id_rs || bus.ex_rw == bus.id_rt);
    assign stall  = !rst && (ld_hit || state_q == LDSTALL || (md_cnt_q != '0 && bus.id_hilo));

    assign bus.fwd_a   = rst ? 2'b00 : gpr_sel(bus.ex_rs, bus.exmem_rw, bus.memwb_rw,
                                               bus.exmem_regwr, bus.memwb_regwr);
    assign bus.fwd_b   = rst ? 2'b00 : gpr_sel(bus.ex_rt, bus.exmem_rw, bus.memwb_rw,
                                               bus.exmem_regwr, bus.memwb_regwr);
    assign bus.fwd_h   = (rst || !bus.ex_mfhi) ? 2'b00 : bus.exmem_mthi ? 2'b01 :
                         bus.memwb_mthi ? 2'b10 : 2'b00;
    assign bus.fwd_l   = (rst || !bus.ex_mflo) ? 2'b00 : bus.exmem_mtlo ? 2'b01 :
                         bus.memwb_mtlo ? 2'b10 : 2'b00;
    assign bus.stall   = stall;
    assign bus.bubble  = stall;
    assign bus.md_busy = !rst && md_cnt_q != '0;

    // a new md_start restarts the countdown even if a previous op is pending
    assign md_cnt_d = bus.md_start ? 4'(MD_LAT) : md_cnt_q - 4'(md_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
            if (state_q == IDLE) begin
                if (ld_hit && LOAD_LAT > 1) begin
                    state_q  <= LDSTALL;
                    ld_cnt_q <= 3'(LOAD_LAT - 1);
                end
            end else begin
                ld_cnt_q <= ld_cnt_q - 3'd1;
                if (ld_cnt_q == 3'd1) state_q <= IDLE;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
    assign bus.stall_cnt = rst ? '0 : stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench with a cycle-level reference model.
module tb_hazard_forward_unit;
    localparam int LL   = 3;
    localparam int MDL  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rw, exmem_rw, memwb_rw;
        logic       id_hilo, ex_memrd, ex_mfhi, ex_mflo, md_start;
        logic       exmem_regwr, memwb_regwr, exmem_mthi, exmem_mtlo, memwb_mthi, memwb_mtlo;
    } stim_t;

    typedef struct packed {
        logic [1:0]    fwd_a, fwd_b, fwd_h, fwd_l;
        logic          stall, bubble, md_busy;
        logic [CW-1:0] stall_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_ld = 0, m_md = 0, m_cnt = 0;
    bit   done = 1'b0;
    exp_t expq[$];

    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();

    hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LAT(LL), .MD_LAT(MDL), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // youngest producer writing the source register wins; r0 is never bypassed
    function automatic logic [1:0] gsel(input logic [4:0] src, input stim_t s);
        logic [4:0] rw[2];
        logic       we[2];
        rw = '{s.exmem_rw, s.memwb_rw};
        we = '{s.exmem_regwr, s.memwb_regwr};
        if (src == 0) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (we[i] && rw[i] == src) return 2'(i + 1);
        return 2'b00;
    endfunction

    function automatic logic [1:0] hsel(input logic rd, em, mw);
        if (!rd) return 2'b00;
        return em ? 2'b01 : mw ? 2'b10 : 2'b00;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   hit, st;
        @(posedge clk);
        #1;
        rst             = s.rst;
        bus.id_rs       = s.id_rs;       bus.id_rt       = s.id_rt;
        bus.ex_rs       = s.ex_rs;       bus.ex_rt       = s.ex_rt;
        bus.ex_rw       = s.ex_rw;       bus.exmem_rw    = s.exmem_rw;
        bus.memwb_rw    = s.memwb_rw;    bus.id_hilo     = s.id_hilo;
        bus.ex_memrd    = s.ex_memrd;    bus.ex_mfhi     = s.ex_mfhi;
        bus.ex_mflo     = s.ex_mflo;     bus.md_start    = s.md_start;
        bus.exmem_regwr = s.exmem_regwr; bus.memwb_regwr = s.memwb_regwr;
        bus.exmem_mthi  = s.exmem_mthi;  bus.exmem_mtlo  = s.exmem_mtlo;
        bus.memwb_mthi  = s.memwb_mthi;  bus.memwb_mtlo  = s.memwb_mtlo;
        hit = s.ex_memrd && s.ex_rw != 0 && (s.ex_rw == s.id_rs || s.ex_rw == s.id_rt);
        st  = !s.rst && (hit || m_ld > 0 || (m_md > 0 && s.id_hilo));
        e.fwd_a     = s.rst ? 2'b00 : gsel(s.ex_rs, s);
        e.fwd_b     = s.rst ? 2'b00 : gsel(s.ex_rt, s);
        e.fwd_h     = s.rst ? 2'b00 : hsel(s.ex_mfhi, s.exmem_mthi, s.memwb_mthi);
        e.fwd_l     = s.rst ? 2'b00 : hsel(s.ex_mflo, s.exmem_mtlo, s.memwb_mtlo);
        e.stall     = st;
        e.bubble    = st;
        e.md_busy   = !s.rst && m_md > 0;
        e.stall_cnt = (PERF && !s.rst) ? CW'(m_cnt) : '0;
        expq.push_back(e);
        if (s.rst) begin
            m_ld = 0; m_md = 0; m_cnt = 0;
        end else begin
            m_ld = (m_ld > 0) ? m_ld - 1 : hit ? LL - 1 : 0;
            m_md = s.md_start ? MDL : (m_md > 0 ? m_md - 1 : 0);
            if (st && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("fwd_a", 32'(bus.fwd_a), 32'(e.fwd_a));
                chk("fwd_b", 32'(bus.fwd_b), 32'(e.fwd_b));
                chk("fwd_h", 32'(bus.fwd_h), 32'(e.fwd_h));
                chk("fwd_l", 32'(bus.fwd_l), 32'(e.fwd_l));
                chk("stall", 32'(bus.stall), 32'(e.stall));
                chk("bubble", 32'(bus.bubble), 32'(e.bubble));
                chk("md_busy", 32'(bus.md_busy), 32'(e.md_busy));
                chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.stall_cnt));
            end
        end
    end

    initial begin
        stim_t s;
        s = nop(); s.rst = 1'b1;
        step(s); step(s);
        s = nop(); s.ex_rs = 5; s.exmem_rw = 5; s.memwb_rw = 5;
        s.exmem_regwr = 1; s.memwb_regwr = 1;
        step(s);
        s.exmem_regwr = 0;
        step(s);
        s = nop(); s.exmem_rw = 0; s.exmem_regwr = 1; s.exmem_mthi = 1; s.ex_mfhi = 1;
        step(s);
        s.memwb_mtlo = 1; s.ex_mflo = 1;
        step(s);
        s = nop(); s.ex_memrd = 1; s.ex_rw = 7; s.id_rt = 7;
        step(s);
        repeat (4) step(nop());
        s = nop(); s.md_start = 1;
        step(s);
        s = nop(); s.id_hilo = 1;
        step(s);
        s.md_start = 1;
        step(s);
        s.md_start = 0;
        repeat (6) step(s);
        s = nop(); s.md_start = 1;
        step(s);
        s = nop(); s.id_hilo = 1; s.ex_memrd = 1; s.ex_rw = 3; s.id_rs = 3;
        step(s);
        s.ex_memrd = 0;
        repeat (4) step(s);
        s = nop(); s.ex_memrd = 1; s.ex_rw = 9; s.id_rs = 9;
        step(s);
        step(nop());
        s = nop(); s.rst = 1;
        step(s);
        repeat (3) step(nop());
        s = nop(); s.id_hilo = 1; s.md_start = 1;
        repeat (20) step(s);
        s = nop(); s.rst = 1;
        step(s);
        for (int i = 0; i < 400; i++) begin
            s.rst         = ($urandom_range(0, 63) == 0);
            s.id_rs       = 5'($urandom_range(0, 3)); s.id_rt    = 5'($urandom_range(0, 3));
            s.ex_rs       = 5'($urandom_range(0, 3)); s.ex_rt    = 5'($urandom_range(0, 3));
            s.ex_rw       = 5'($urandom_range(0, 3)); s.exmem_rw = 5'($urandom_range(0, 3));
            s.memwb_rw    = 5'($urandom_range(0, 3));
            s.id_hilo     = 1'($urandom);           s.ex_memrd    = ($urandom_range(0, 3) == 0);
            s.ex_mfhi     = 1'($urandom);           s.ex_mflo     = 1'($urandom);
            s.md_start    = ($urandom_range(0, 7) == 0);
            s.exmem_regwr = 1'($urandom);           s.memwb_regwr = 1'($urandom);
            s.exmem_mthi  = 1'($urandom);           s.exmem_mtlo  = 1'($urandom);
            s.memwb_mthi  = 1'($urandom);           s.memwb_mtlo  = 1'($urandom);
            step(s);
        end
        step(nop());
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
